// File: rtl/pd_pwr_responder.sv
// Domain-side power handshake responder.
// Drains before sleep ack, models rail ramp before power-on ack.
module pd_pwr_responder #(
  parameter int CNT_W       = 8,
  parameter int IDLE_HOLD   = 4,
  parameter int DRAIN_MAX   = 200,
  parameter int RAMP_CYCLES = 16,
  parameter bit RESET_ON    = 1'b1
) (
  input  logic       i_aon_clk,
  input  logic       i_soc_pwr_on_rst,
  input  logic       i_hw_sleep_req,
  input  logic       i_pwr_on_req,
  input  logic       i_iso,
  input  logic       i_ret,
  input  logic       i_idle,
  output logic       o_hw_sleep_ack,
  output logic       o_pwr_on_ack,
  output logic       o_pwr_good,
  output logic       o_ret_valid,
  output logic [2:0] o_state,
  output logic       o_drain_timeout,
  output logic       o_proto_err
);

  typedef enum logic [2:0] {
    ON      = 3'd0,
    DRAIN   = 3'd1,
    SLP_ACK = 3'd2,
    OFF     = 3'd3,
    RAMP    = 3'd4,
    ON_ACK  = 3'd5
  } state_t;

  localparam state_t RST_ST = RESET_ON ? ON : OFF;
  localparam logic [CNT_W-1:0] IDLE_LIM  = CNT_W'(IDLE_HOLD);
  localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(DRAIN_MAX);
  localparam logic [CNT_W-1:0] RAMP_LIM  = CNT_W'(RAMP_CYCLES);

  state_t           state, state_n;
  logic [CNT_W-1:0] drain_cnt, drain_n;
  logic [CNT_W-1:0] idle_cnt, idle_n;
  logic [CNT_W-1:0] ramp_cnt, ramp_n;
  logic             ret_n, perr_n, dto_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign o_state = state;

  // Next state, counters and sticky flags.
  always_comb begin
    state_n = state;
    drain_n = drain_cnt;
    idle_n  = idle_cnt;
    ramp_n  = ramp_cnt;
    ret_n   = o_ret_valid;
    perr_n  = o_proto_err;
    dto_n   = o_drain_timeout;
    unique case (state)
      ON: begin
        if (i_pwr_on_req) perr_n = 1'b1;
        if (i_hw_sleep_req) begin
          state_n = DRAIN;
          drain_n = '0;
          idle_n  = '0;
        end
      end
      DRAIN: begin
        if (!i_hw_sleep_req) begin
          state_n = ON;
        end else begin
          drain_n = sat_inc(drain_cnt);
          idle_n  = i_idle ? sat_inc(idle_cnt) : '0;
          if (idle_n >= IDLE_LIM) begin
            state_n = SLP_ACK;
          end else if (drain_n >= DRAIN_LIM) begin
            state_n = SLP_ACK;
            dto_n   = 1'b1;
          end
        end
      end
      SLP_ACK: begin
        if (!i_hw_sleep_req) begin
          if (i_iso) begin
            state_n = OFF;
            ret_n   = i_ret;
          end else begin
            state_n = ON;
          end
        end
      end
      OFF: begin
        if (i_hw_sleep_req) perr_n = 1'b1;
        if (i_pwr_on_req) begin
          state_n = RAMP;
          ramp_n  = '0;
        end
      end
      RAMP: begin
        if (!i_pwr_on_req) begin
          state_n = OFF;
        end else begin
          ramp_n = sat_inc(ramp_cnt);
          if (ramp_n >= RAMP_LIM) state_n = ON_ACK;
        end
      end
      ON_ACK: begin
        if (i_hw_sleep_req) perr_n = 1'b1;
        if (!i_pwr_on_req) begin
          state_n = ON;
          ret_n   = 1'b0;
        end
      end
      default: state_n = RST_ST;
    endcase
  end

  // State, counters and registered outputs decoded from next state.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      state           <= RST_ST;
      drain_cnt       <= '0;
      idle_cnt        <= '0;
      ramp_cnt        <= '0;
      o_hw_sleep_ack  <= 1'b0;
      o_pwr_on_ack    <= 1'b0;
      o_pwr_good      <= RESET_ON;
      o_ret_valid     <= 1'b0;
      o_drain_timeout <= 1'b0;
      o_proto_err     <= 1'b0;
    end else begin
      state           <= state_n;
      drain_cnt       <= drain_n;
      idle_cnt        <= idle_n;
      ramp_cnt        <= ramp_n;
      o_hw_sleep_ack  <= (state_n == SLP_ACK);
      o_pwr_on_ack    <= (state_n == ON_ACK);
      o_pwr_good      <= !((state_n == OFF) || (state_n == RAMP));
      o_ret_valid     <= ret_n;
      o_drain_timeout <= dto_n;
      o_proto_err     <= perr_n;
    end
  end

endmodule

// File: tb/tb_pd_pwr_responder.sv
// Bench for pd_pwr_responder.
// Expected snapshots queued with stimulus, scored per scenario.
module tb_pd_pwr_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slp = 1'b0;
  logic pon = 1'b0;
  logic iso = 1'b0;
  logic ret = 1'b0;
  logic idle = 1'b0;
  logic sa, pa, pg, rv, dto, pe;
  logic [2:0] st;

  int total = 0;
  int bad = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  string nm_q[$];

  localparam logic [2:0] S_ON  = 3'd0;
  localparam logic [2:0] S_DR  = 3'd1;
  localparam logic [2:0] S_SA  = 3'd2;
  localparam logic [2:0] S_OFF = 3'd3;
  localparam logic [2:0] S_RP  = 3'd4;
  localparam logic [2:0] S_OA  = 3'd5;

  always #5 clk = ~clk;

  pd_pwr_responder dut (
    .i_aon_clk(clk),
    .i_soc_pwr_on_rst(rst),
    .i_hw_sleep_req(slp),
    .i_pwr_on_req(pon),
    .i_iso(iso),
    .i_ret(ret),
    .i_idle(idle),
    .o_hw_sleep_ack(sa),
    .o_pwr_on_ack(pa),
    .o_pwr_good(pg),
    .o_ret_valid(rv),
    .o_state(st),
    .o_drain_timeout(dto),
    .o_proto_err(pe)
  );

  // Packed {state, sleep_ack, on_ack, pwr_good, ret_valid, timeout, proto_err}
  function automatic logic [8:0] mk(logic [2:0] s, logic a, logic b,
                                    logic g, logic r, logic t, logic p);
    return {s, a, b, g, r, t, p};
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic look(string n, logic [8:0] e);
    exp_q.push_back(e);
    obs_q.push_back({st, sa, pa, pg, rv, dto, pe});
    nm_q.push_back(n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    look("reset", mk(S_ON, 0, 0, 1, 0, 0, 0));
    rst = 1'b0;
    tick(1);
    look("post_reset", mk(S_ON, 0, 0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      logic [8:0] e, o;
      string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_sleep_clean;
    idle = 1; iso = 1; ret = 1; slp = 1;
    tick(1); look("slp_drain1", mk(S_DR, 0, 0, 1, 0, 0, 0));
    tick(3); look("slp_drain4", mk(S_DR, 0, 0, 1, 0, 0, 0));
    tick(1); look("slp_ack", mk(S_SA, 1, 0, 1, 0, 0, 0));
    tick(2); look("slp_ack_hold", mk(S_SA, 1, 0, 1, 0, 0, 0));
    slp = 0;
    tick(1); look("slp_off", mk(S_OFF, 0, 0, 0, 1, 0, 0));
    while (exp_q.size() > 0) begin
      logic [8:0] e, o;
      string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_wake;
    pon = 1;
    tick(1); look("wake_ramp1", mk(S_RP, 0, 0, 0, 1, 0, 0));
    tick(15); look("wake_ramp16", mk(S_RP, 0, 0, 0, 1, 0, 0));
    tick(1); look("wake_ack", mk(S_OA, 0, 1, 1, 1, 0, 0));
    pon = 0;
    tick(1); look("wake_on", mk(S_ON, 0, 0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      logic [8:0] e, o;
      string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_drain_abort;
    idle = 0; slp = 1;
    tick(1); look("abort_drain1", mk(S_DR, 0, 0, 1, 0, 0, 0));
    tick(5); look("abort_drain6", mk(S_DR, 0, 0, 1, 0, 0, 0));
    slp = 0;
    tick(1); look("abort_on", mk(S_ON, 0, 0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      logic [8:0] e, o;
      string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_drain_timeout;
    idle = 0; slp = 1;
    tick(1); look("to_drain1", mk(S_DR, 0, 0, 1, 0, 0, 0));
    tick(199); look("to_drain200", mk(S_DR, 0, 0, 1, 0, 0, 0));
    tick(1); look("to_ack", mk(S_SA, 1, 0, 1, 0, 1, 0));
    iso = 0; slp = 0;
    tick(1); look("to_cancel_on", mk(S_ON, 0, 0, 1, 0, 1, 0));
    tick(3); look("to_sticky", mk(S_ON, 0, 0, 1, 0, 1, 0));
    while (exp_q.size() > 0) begin
      logic [8:0] e, o;
      string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_protocol;
    rst = 1; #1;
    look("proto_rst_clear", mk(S_ON, 0, 0, 1, 0, 0, 0));
    tick(1); rst = 0;
    pon = 1;
    tick(1); look("proto_on_req_in_on", mk(S_ON, 0, 0, 1, 0, 0, 1));
    pon = 0;
    tick(1);
    rst = 1; #1;
    tick(1); rst = 0;
    idle = 1; iso = 1; ret = 0; slp = 1;
    tick(5); look("proto_to_ack", mk(S_SA, 1, 0, 1, 0, 0, 0));
    slp = 0;
    tick(1); look("proto_off_noret", mk(S_OFF, 0, 0, 0, 0, 0, 0));
    slp = 1;
    tick(1); look("proto_sleep_in_off", mk(S_OFF, 0, 0, 0, 0, 0, 1));
    tick(2); look("proto_stay_off", mk(S_OFF, 0, 0, 0, 0, 0, 1));
    slp = 0;
    while (exp_q.size() > 0) begin
      logic [8:0] e, o;
      string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_ramp_abort;
    pon = 1;
    tick(1); look("rab_ramp1", mk(S_RP, 0, 0, 0, 0, 0, 1));
    tick(7); look("rab_ramp8", mk(S_RP, 0, 0, 0, 0, 0, 1));
    pon = 0;
    tick(1); look("rab_off", mk(S_OFF, 0, 0, 0, 0, 0, 1));
    while (exp_q.size() > 0) begin
      logic [8:0] e, o;
      string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_ramp;
    pon = 1;
    tick(1); look("mr_ramp1", mk(S_RP, 0, 0, 0, 0, 0, 1));
    tick(4); look("mr_ramp5", mk(S_RP, 0, 0, 0, 0, 0, 1));
    rst = 1; #1;
    look("mr_async_rst", mk(S_ON, 0, 0, 1, 0, 0, 0));
    pon = 0;
    tick(1); rst = 0;
    tick(1); look("mr_after_rst", mk(S_ON, 0, 0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      logic [8:0] e, o;
      string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    idle = 1; iso = 1; ret = 1; slp = 1;
    tick(5); look("b2b_ack", mk(S_SA, 1, 0, 1, 0, 0, 0));
    slp = 0; pon = 1;
    tick(1); look("b2b_off", mk(S_OFF, 0, 0, 0, 1, 0, 0));
    tick(1); look("b2b_ramp", mk(S_RP, 0, 0, 0, 1, 0, 0));
    tick(16); look("b2b_on_ack", mk(S_OA, 0, 1, 1, 1, 0, 0));
    pon = 0; slp = 1;
    tick(1); look("b2b_on_err", mk(S_ON, 0, 0, 1, 0, 0, 1));
    tick(1); look("b2b_drain", mk(S_DR, 0, 0, 1, 0, 0, 1));
    slp = 0;
    tick(1); look("b2b_abort", mk(S_ON, 0, 0, 1, 0, 0, 1));
    while (exp_q.size() > 0) begin
      logic [8:0] e, o;
      string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, o, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_sleep_clean;
    test_wake;
    test_drain_abort;
    test_drain_timeout;
    test_protocol;
    test_ramp_abort;
    test_reset_mid_ramp;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
